// File: rtl/frota_placement_ctrl.sv
// Fleet placement sequencer: cursor-driven preview, bounds clamping, overlap check, commit into occupancy.
// Optional FROTA_ADJACENCY_CHECK_EN: also reject ships touching (incl. diagonally) a committed cell.
module frota_placement_ctrl #(
  parameter int SHIP0_LEN = 1,
  parameter int SHIP1_LEN = 2,
  parameter int SHIP2_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  input  logic        btn_confirm,
  output logic [63:0] pos_ship0,
  output logic [63:0] pos_ship1,
  output logic [63:0] pos_ship2,
  output logic [63:0] occupancy,
  output logic [1:0]  ship_sel,
  output logic        placing,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {S_IDLE, S_PLACE, S_CHECK, S_COMMIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic             vert_q, vert_d;
  logic [1:0]       sel_q, sel_d;
  logic [63:0]      occ_q, occ_d;
  logic [2:0][63:0] pos_q, pos_d;
  logic             placing_q, placing_d, done_q, done_d, error_q, error_d;

  logic [3:0]  len;
  logic [4:0]  end_x, end_y, rot_end;
  logic [63:0] act_mask, prev;
  logic        clash;

  localparam logic [63:0] COL1 = 64'h0101_0101_0101_0101;
  localparam logic [63:0] COL8 = 64'h8080_8080_8080_8080;

  function automatic logic [3:0] ship_len(input logic [1:0] s);
    case (s)
      2'd0:    return 4'(SHIP0_LEN);
      2'd1:    return 4'(SHIP1_LEN);
      default: return 4'(SHIP2_LEN);
    endcase
  endfunction

  function automatic logic [63:0] pack_cells(input logic [3:0] x, input logic [3:0] y,
                                             input logic v, input logic [3:0] l);
    logic [63:0] p;
    p = '0;
    for (int k = 0; k < 6; k++) begin
      if (4'(k) < l) begin
        p[8*k+3 +: 4] = v ? x : x + 4'(k);
        p[8*k+7 +: 4] = v ? y + 4'(k) : y;
      end
    end
    return p;
  endfunction

  function automatic logic [63:0] cell_mask(input logic [3:0] x, input logic [3:0] y,
                                            input logic v, input logic [3:0] l);
    logic [63:0] m;
    logic [3:0]  xx, yy;
    logic [5:0]  idx;
    m = '0;
    for (int k = 0; k < 6; k++) begin
      xx  = v ? x : x + 4'(k);
      yy  = v ? y + 4'(k) : y;
      idx = {3'(yy - 4'd1), 3'(xx - 4'd1)};
      if (4'(k) < l) m[idx] = 1'b1;
    end
    return m;
  endfunction

  // Grow a cell map by one cell in all 8 directions; column masks stop row wrap.
  function automatic logic [63:0] dilate(input logic [63:0] m);
    logic [63:0] h;
    h = m | ((m << 1) & ~COL1) | ((m >> 1) & ~COL8);
    return h | (h << 8) | (h >> 8);
  endfunction

  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    vert_d   = vert_q;
    sel_d    = sel_q;
    occ_d    = occ_q;
    pos_d    = pos_q;
    error_d  = 1'b0;
    len      = ship_len(sel_q);
    end_x    = {1'b0, cur_x_q} + (vert_q ? 5'd0 : {1'b0, len} - 5'd1);
    end_y    = {1'b0, cur_y_q} + (vert_q ? {1'b0, len} - 5'd1 : 5'd0);
    rot_end  = (vert_q ? {1'b0, cur_x_q} : {1'b0, cur_y_q}) + {1'b0, len} - 5'd1;
    act_mask = cell_mask(cur_x_q, cur_y_q, vert_q, len);
`ifdef FROTA_ADJACENCY_CHECK_EN
    clash    = |(dilate(act_mask) & occ_q);
`else
    clash    = |(act_mask & occ_q);
`endif
    if (start) begin
      state_d = S_PLACE;
      occ_d   = '0;
      pos_d   = '0;
      sel_d   = 2'd0;
      cur_x_d = 4'd1;
      cur_y_d = 4'd1;
      vert_d  = 1'b0;
    end else begin
      case (state_q)
        S_PLACE: begin
          if (btn_confirm)      state_d = S_CHECK;
          else if (btn_rotate)  begin if (rot_end <= 5'd8)  vert_d  = ~vert_q;          end
          else if (btn_up)      begin if (end_y < 5'd8)     cur_y_d = cur_y_q + 4'd1;  end
          else if (btn_down)    begin if (cur_y_q > 4'd1)   cur_y_d = cur_y_q - 4'd1;  end
          else if (btn_left)    begin if (cur_x_q > 4'd1)   cur_x_d = cur_x_q - 4'd1;  end
          else if (btn_right)   begin if (end_x < 5'd8)     cur_x_d = cur_x_q + 4'd1;  end
        end
        S_CHECK: begin
          if (clash) begin
            error_d = 1'b1;
            state_d = S_PLACE;
          end else begin
            state_d = S_COMMIT;
          end
        end
        S_COMMIT: begin
          occ_d = occ_q | act_mask;
          if (sel_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            sel_d   = sel_q + 2'd1;
            cur_x_d = 4'd1;
            cur_y_d = 4'd1;
            vert_d  = 1'b0;
            state_d = S_PLACE;
          end
        end
        default: ;
      endcase
    end
    // Preview of the active ship follows the next cursor; committed entries are left alone.
    prev = pack_cells(cur_x_d, cur_y_d, vert_d, ship_len(sel_d));
    if (!start && (state_d == S_PLACE || state_d == S_CHECK)) begin
      case (sel_d)
        2'd0:    pos_d[0] = prev;
        2'd1:    pos_d[1] = prev;
        default: pos_d[2] = prev;
      endcase
    end
    placing_d = (state_d == S_PLACE) || (state_d == S_CHECK);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_x_q   <= 4'd1;
      cur_y_q   <= 4'd1;
      vert_q    <= 1'b0;
      sel_q     <= 2'd0;
      occ_q     <= '0;
      pos_q     <= '0;
      placing_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      vert_q    <= vert_d;
      sel_q     <= sel_d;
      occ_q     <= occ_d;
      pos_q     <= pos_d;
      placing_q <= placing_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign pos_ship0 = pos_q[0];
  assign pos_ship1 = pos_q[1];
  assign pos_ship2 = pos_q[2];
  assign occupancy = occ_q;
  assign ship_sel  = sel_q;
  assign placing   = placing_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_frota_placement_ctrl.sv
// Bench for frota_placement_ctrl: directed scenarios plus random button traffic against a cell-level fleet model.
module tb_frota_placement_ctrl;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic btn_rotate = 1'b0, btn_confirm = 1'b0;
  logic [63:0] pos_ship0, pos_ship1, pos_ship2, occupancy;
  logic [1:0]  ship_sel;
  logic        placing, done, error;

  int n_cmp = 0, n_bad = 0, err_cnt = 0, exp_err = 0;

  // Model: 0 idle, 1 placing, 2 done; cursor, board cells, frozen ship vectors.
  int          m_state = 0, m_sel = 0, m_x = 1, m_y = 1;
  bit          m_vert = 1'b0;
  bit          m_occ [64];
  logic [63:0] m_pos [3];

  localparam bit [6:0] B_ST = 7'b1000000, B_CF = 7'b0100000, B_RO = 7'b0010000,
                       B_UP = 7'b0001000, B_DN = 7'b0000100, B_LF = 7'b0000010, B_RT = 7'b0000001;

  always #5 clk = ~clk;

  frota_placement_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_rotate(btn_rotate), .btn_confirm(btn_confirm),
    .pos_ship0(pos_ship0), .pos_ship1(pos_ship1), .pos_ship2(pos_ship2),
    .occupancy(occupancy), .ship_sel(ship_sel), .placing(placing), .done(done), .error(error)
  );

  function automatic int len_of(int s);
    return (s == 0) ? 1 : (s == 1) ? 2 : 3;
  endfunction

  function automatic bit fits(int x, int y, bit v, int l);
    if (x < 1 || y < 1) return 1'b0;
    return v ? (x <= 8 && y + l - 1 <= 8) : (x + l - 1 <= 8 && y <= 8);
  endfunction

  function automatic logic [63:0] cells_packed(int x, int y, bit v, int l);
    logic [63:0] p;
    int cx, cy;
    p = '0;
    for (int k = 0; k < l; k++) begin
      cx = v ? x : x + k;
      cy = v ? y + k : y;
      p = p | (64'(cx) << (8*k + 3)) | (64'(cy) << (8*k + 7));
    end
    return p;
  endfunction

  function automatic logic [63:0] occ_vec();
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[i] = m_occ[i];
    return o;
  endfunction

  function automatic bit clashes(int x, int y, bit v, int l);
    int cx, cy, nx, ny;
    for (int k = 0; k < l; k++) begin
      cx = v ? x : x + k;
      cy = v ? y + k : y;
`ifdef FROTA_ADJACENCY_CHECK_EN
      for (int dx = -1; dx <= 1; dx++)
        for (int dy = -1; dy <= 1; dy++) begin
          nx = cx + dx;
          ny = cy + dy;
          if (nx >= 1 && nx <= 8 && ny >= 1 && ny <= 8 && m_occ[(ny-1)*8 + nx-1]) return 1'b1;
        end
`else
      nx = cx; ny = cy;
      if (m_occ[(ny-1)*8 + nx-1]) return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_pos(int i);
    if (m_state == 1 && i == m_sel) return cells_packed(m_x, m_y, m_vert, len_of(m_sel));
    return m_pos[i];
  endfunction

  task automatic model_apply(input bit [6:0] b);
    int l;
    exp_err = 0;
    l = len_of(m_sel);
    if (b[6]) begin
      m_state = 1; m_sel = 0; m_x = 1; m_y = 1; m_vert = 1'b0;
      foreach (m_occ[i]) m_occ[i] = 1'b0;
      foreach (m_pos[i]) m_pos[i] = '0;
    end else if (m_state == 1) begin
      if (b[5]) begin
        if (clashes(m_x, m_y, m_vert, l)) exp_err = 1;
        else begin
          for (int k = 0; k < l; k++)
            m_occ[((m_vert ? m_y + k : m_y) - 1)*8 + (m_vert ? m_x : m_x + k) - 1] = 1'b1;
          m_pos[m_sel] = cells_packed(m_x, m_y, m_vert, l);
          if (m_sel == 2) m_state = 2;
          else begin m_sel++; m_x = 1; m_y = 1; m_vert = 1'b0; end
        end
      end
      else if (b[4]) begin if (fits(m_x, m_y, !m_vert, l))     m_vert = !m_vert; end
      else if (b[3]) begin if (fits(m_x, m_y + 1, m_vert, l))  m_y++; end
      else if (b[2]) begin if (fits(m_x, m_y - 1, m_vert, l))  m_y--; end
      else if (b[1]) begin if (fits(m_x - 1, m_y, m_vert, l))  m_x--; end
      else if (b[0]) begin if (fits(m_x + 1, m_y, m_vert, l))  m_x++; end
    end
  endtask

  // One-cycle button pulse, then let the DUT settle while counting error cycles.
  task automatic step(input bit [6:0] b);
    @(negedge clk);
    {start, btn_confirm, btn_rotate, btn_up, btn_down, btn_left, btn_right} = b;
    @(negedge clk);
    {start, btn_confirm, btn_rotate, btn_up, btn_down, btn_left, btn_right} = '0;
    err_cnt = int'(error);
    repeat (5) begin @(negedge clk); err_cnt += int'(error); end
    model_apply(b);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if ({pos_ship0, pos_ship1, pos_ship2, occupancy} !== '0) begin n_bad++;
      $display("FAIL reset_vectors got=%h %h %h %h want=0", pos_ship0, pos_ship1, pos_ship2, occupancy); end
    n_cmp++; if ({ship_sel, placing, done, error} !== 5'b0) begin n_bad++;
      $display("FAIL reset_flags got=%b want=00000", {ship_sel, placing, done, error}); end
    rst_n = 1'b1;
    step(B_CF);
    n_cmp++; if (placing !== 1'b0 || pos_ship0 !== 64'h0) begin n_bad++;
      $display("FAIL idle_ignores_btn placing=%b pos0=%h want 0/0", placing, pos_ship0); end
  endtask

  task automatic test_first_ship();
    step(B_ST);
    n_cmp++; if (pos_ship0 !== 64'h88 || placing !== 1'b1) begin n_bad++;
      $display("FAIL start_preview pos0=%h placing=%b want 88/1", pos_ship0, placing); end
    step(B_CF);
    n_cmp++; if (pos_ship0 !== 64'h88) begin n_bad++;
      $display("FAIL ship0_pos got=%h want=88", pos_ship0); end
    n_cmp++; if (occupancy !== 64'h1 || ship_sel !== 2'd1 || err_cnt != 0) begin n_bad++;
      $display("FAIL ship0_commit occ=%h sel=%0d err=%0d want 1/1/0", occupancy, ship_sel, err_cnt); end
  endtask

  task automatic test_ship1();
    repeat (4) step(B_UP);
    repeat (2) step(B_RT);
    n_cmp++; if (pos_ship1 !== 64'h2A298) begin n_bad++;
      $display("FAIL ship1_preview got=%h want=2a298", pos_ship1); end
    step(B_CF);
    n_cmp++; if (pos_ship1 !== 64'h2A298 || occupancy !== 64'h0000_000C_0000_0001) begin n_bad++;
      $display("FAIL ship1_commit pos1=%h occ=%h want 2a298/c00000001", pos_ship1, occupancy); end
    n_cmp++; if (ship_sel !== 2'd2) begin n_bad++;
      $display("FAIL ship1_sel got=%0d want=2", ship_sel); end
  endtask

  task automatic test_clamp();
    repeat (10) step(B_RT);
    n_cmp++; if (pos_ship2 !== 64'hC0B8B0 || pos_ship2 !== cells_packed(6, 1, 1'b0, 3)) begin n_bad++;
      $display("FAIL clamp_right got=%h want=c0b8b0", pos_ship2); end
    repeat (6) step(B_UP);
    n_cmp++; if (pos_ship2 !== cells_packed(6, 7, 1'b0, 3)) begin n_bad++;
      $display("FAIL move_up got=%h want=%h", pos_ship2, cells_packed(6, 7, 1'b0, 3)); end
    step(B_RO);
    n_cmp++; if (pos_ship2 !== cells_packed(6, 7, 1'b0, 3)) begin n_bad++;
      $display("FAIL rotate_blocked got=%h want=%h", pos_ship2, cells_packed(6, 7, 1'b0, 3)); end
  endtask

  task automatic test_overlap();
    repeat (3) step(B_LF);
    repeat (2) step(B_DN);
    step(B_CF);
    n_cmp++; if (err_cnt != 1) begin n_bad++;
      $display("FAIL overlap_error_cycles got=%0d want=1", err_cnt); end
    n_cmp++; if (placing !== 1'b1 || occupancy !== 64'h0000_000C_0000_0001 || ship_sel !== 2'd2) begin n_bad++;
      $display("FAIL overlap_state placing=%b occ=%h sel=%0d", placing, occupancy, ship_sel); end
    n_cmp++; if (pos_ship2 !== cells_packed(3, 5, 1'b0, 3)) begin n_bad++;
      $display("FAIL overlap_cursor got=%h want=%h", pos_ship2, cells_packed(3, 5, 1'b0, 3)); end
    repeat (2) step(B_UP);
    step(B_CF);
    n_cmp++; if (done !== 1'b1 || placing !== 1'b0 || err_cnt != 0) begin n_bad++;
      $display("FAIL fleet_done done=%b placing=%b err=%0d want 1/0/0", done, placing, err_cnt); end
    n_cmp++; if (occupancy !== occ_vec()) begin n_bad++;
      $display("FAIL fleet_occ got=%h want=%h", occupancy, occ_vec()); end
  endtask

  task automatic test_restart();
    step(B_UP | B_CF);
    n_cmp++; if (pos_ship2 !== m_pos[2] || done !== 1'b1) begin n_bad++;
      $display("FAIL done_ignores_btn pos2=%h done=%b want %h/1", pos_ship2, done, m_pos[2]); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++; if ({pos_ship0, pos_ship1, pos_ship2, occupancy} !== '0) begin n_bad++;
      $display("FAIL restart_clear got=%h %h %h %h want=0", pos_ship0, pos_ship1, pos_ship2, occupancy); end
    n_cmp++; if (ship_sel !== 2'd0 || placing !== 1'b1 || done !== 1'b0) begin n_bad++;
      $display("FAIL restart_flags sel=%0d placing=%b done=%b want 0/1/0", ship_sel, placing, done); end
    repeat (4) @(negedge clk);
    model_apply(B_ST);
  endtask

  task automatic test_priority();
    step(B_CF | B_RT);
    n_cmp++; if (pos_ship0 !== 64'h88 || ship_sel !== 2'd1) begin n_bad++;
      $display("FAIL confirm_over_right pos0=%h sel=%0d want 88/1", pos_ship0, ship_sel); end
    step(B_UP | B_DN | B_LF);
    n_cmp++; if (pos_ship1 !== cells_packed(1, 2, 1'b0, 2)) begin n_bad++;
      $display("FAIL up_over_down got=%h want=%h", pos_ship1, cells_packed(1, 2, 1'b0, 2)); end
  endtask

  task automatic test_adjacency();
    step(B_ST);
    step(B_CF);
    step(B_RT);
    step(B_UP);
    step(B_RO);
    n_cmp++; if (pos_ship1 !== cells_packed(2, 2, 1'b1, 2)) begin n_bad++;
      $display("FAIL vertical_preview got=%h want=%h", pos_ship1, cells_packed(2, 2, 1'b1, 2)); end
    step(B_CF);
`ifdef FROTA_ADJACENCY_CHECK_EN
    n_cmp++; if (err_cnt != 1 || ship_sel !== 2'd1) begin n_bad++;
      $display("FAIL adjacent_reject err=%0d sel=%0d want 1/1", err_cnt, ship_sel); end
`else
    n_cmp++; if (err_cnt != 0 || ship_sel !== 2'd2) begin n_bad++;
      $display("FAIL adjacent_allow err=%0d sel=%0d want 0/2", err_cnt, ship_sel); end
`endif
  endtask

  task automatic test_random();
    bit [6:0] b;
    logic [63:0] got [3];
    step(B_ST);
    for (int i = 0; i < 300; i++) begin
      b = '0;
      b[6] = ($urandom_range(29) == 0);
      b[5] = ($urandom_range(7) == 0);
      for (int j = 0; j < 5; j++) b[j] = ($urandom_range(3) == 0);
      step(b);
      got = '{pos_ship0, pos_ship1, pos_ship2};
      for (int s = 0; s < 3; s++) begin
        n_cmp++; if (got[s] !== exp_pos(s)) begin n_bad++;
          $display("FAIL rnd%0d pos_ship%0d got=%h want=%h", i, s, got[s], exp_pos(s)); end
      end
      n_cmp++; if (occupancy !== occ_vec()) begin n_bad++;
        $display("FAIL rnd%0d occupancy got=%h want=%h", i, occupancy, occ_vec()); end
      n_cmp++; if (ship_sel !== 2'(m_sel) || placing !== (m_state == 1) || done !== (m_state == 2)) begin n_bad++;
        $display("FAIL rnd%0d flags sel=%0d placing=%b done=%b want %0d/%0d/%0d",
                 i, ship_sel, placing, done, m_sel, m_state == 1, m_state == 2); end
      n_cmp++; if (err_cnt != exp_err) begin n_bad++;
        $display("FAIL rnd%0d error_cycles got=%0d want=%0d", i, err_cnt, exp_err); end
    end
  endtask

  initial begin
    foreach (m_occ[i]) m_occ[i] = 1'b0;
    foreach (m_pos[i]) m_pos[i] = '0;
    test_reset();
    test_first_ship();
    test_ship1();
    test_clamp();
    test_overlap();
    test_restart();
    test_priority();
    test_adjacency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
